// File: rtl/tmds_ddr_serializer.sv
// ---------------------------------------------------------------------------
// tmds_ddr_serializer
// 10:1 serializer for one TMDS/LVDS-style lane, clocked by the 5x serial clock.
// A 10-bit word is split into even/odd halves, shifted out through a
// double-data-rate output stage (both serialclk edges), and driven as a
// complementary p/n pair through a registered tristate control.
//
// Ports
//   serialclk : serial clock, both edges used by the DDR stage
//   rst       : asynchronous active-high reset
//   pdata     : parallel word, bit 0 transmitted first, sampled on the load edge
//   ti        : tristate request, 1 = outputs high-Z after the next rising edge
//   load      : high in the cycle whose closing rising edge samples pdata
//   sdata_p   : serial data, true polarity (tristatable)
//   sdata_n   : serial data, complement (tristatable)
// ---------------------------------------------------------------------------
module tmds_ddr_serializer #(
    parameter int   PAR_WIDTH = 10,
    parameter logic TQ_INIT   = 1'b0
) (
    input  logic                 serialclk,
    input  logic                 rst,
    input  logic [PAR_WIDTH-1:0] pdata,
    input  logic                 ti,
    output logic                 load,
    output logic                 sdata_p,
    output logic                 sdata_n
);

    logic [2:0] cnt_q, cnt_d;
    logic [4:0] sh_h_q, sh_h_d;
    logic [4:0] sh_l_q, sh_l_d;
    logic       q0_p_q, q0_p_d;
    logic       q1_p_q, q1_p_d;
    logic       q1n_p_q, q1n_p_d;
    logic       q0_n_q, q0_n_d;
    logic       q1_n_q, q1_n_d;
    logic       q1n_n_q, q1n_n_d;
    logic       tq_q, tq_d;

    assign load = (cnt_q == 3'd4);

    always_comb begin
        cnt_d  = (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
        sh_h_d = {1'b0, sh_h_q[4:1]};
        sh_l_d = {1'b0, sh_l_q[4:1]};
        if (load) begin
            sh_h_d = {pdata[8], pdata[6], pdata[4], pdata[2], pdata[0]};
            sh_l_d = {pdata[9], pdata[7], pdata[5], pdata[3], pdata[1]};
        end
        q0_p_d  = sh_h_q[0];
        q1_p_d  = sh_l_q[0];
        q0_n_d  = ~sh_h_q[0];
        q1_n_d  = ~sh_l_q[0];
        // Low-phase bits are re-registered on the falling edge so the mux
        // input is already stable when serialclk switches the selection.
        q1n_p_d = q1_p_q;
        q1n_n_d = q1_n_q;
        tq_d    = ti;
    end

    always_ff @(posedge serialclk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 3'd0;
            sh_h_q <= 5'd0;
            sh_l_q <= 5'd0;
            q0_p_q <= 1'b0;
            q1_p_q <= 1'b0;
            q0_n_q <= 1'b1;
            q1_n_q <= 1'b1;
            tq_q   <= TQ_INIT;
        end else begin
            cnt_q  <= cnt_d;
            sh_h_q <= sh_h_d;
            sh_l_q <= sh_l_d;
            q0_p_q <= q0_p_d;
            q1_p_q <= q1_p_d;
            q0_n_q <= q0_n_d;
            q1_n_q <= q1_n_d;
            tq_q   <= tq_d;
        end
    end

    always_ff @(negedge serialclk or posedge rst) begin
        if (rst) begin
            q1n_p_q <= 1'b0;
            q1n_n_q <= 1'b1;
        end else begin
            q1n_p_q <= q1n_p_d;
            q1n_n_q <= q1n_n_d;
        end
    end

    // High phase carries the even bit, low phase the odd bit.
    assign sdata_p = tq_q ? 1'bz : (serialclk ? q0_p_q : q1n_p_q);
    assign sdata_n = tq_q ? 1'bz : (serialclk ? q0_n_q : q1n_n_q);

endmodule

// File: tb/tb_tmds_ddr_serializer.sv
module tb_tmds_ddr_serializer;

    logic       serialclk;
    logic       rst;
    logic [9:0] pdata;
    logic       ti;
    logic       load;
    wire        sdata_p_w;
    wire        sdata_n_w;

    // High-Z on both lines reads as 1/1, which a driven complementary pair
    // never shows.
    pullup (sdata_p_w);
    pullup (sdata_n_w);

    int checks = 0;
    int errors = 0;

    logic [9:0] tx_words [4];
    logic [9:0] rx_p [4];
    logic [9:0] rx_n [4];
    int         load_errs;

    tmds_ddr_serializer #(.PAR_WIDTH(10), .TQ_INIT(1'b0)) dut (
        .serialclk (serialclk),
        .rst       (rst),
        .pdata     (pdata),
        .ti        (ti),
        .load      (load),
        .sdata_p   (sdata_p_w),
        .sdata_n   (sdata_n_w)
    );

    initial serialclk = 1'b0;
    always #5 serialclk = ~serialclk;

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge serialclk); #2;
            if (load === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_load: load never rose within 20 cycles (got %b, need 1)", load);
    endtask

    // Presents tx_words[0..n-1] on consecutive load edges and captures the
    // serial stream bit by bit. With glitch set, pdata is scrambled in every
    // non-load cycle and the real word only appears just before its load edge.
    task automatic xmit(input int n, input bit glitch);
        bit ok;
        load_errs = 0;
        wait_load(ok);
        if (!ok) return;
        pdata = tx_words[0];
        @(posedge serialclk);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge serialclk); #2;
                if (load !== (k == 3)) load_errs++;
                rx_p[i][2*k] = sdata_p_w;
                rx_n[i][2*k] = sdata_n_w;
                if (glitch) pdata = 10'($urandom);
                @(negedge serialclk); #2;
                rx_p[i][2*k+1] = sdata_p_w;
                rx_n[i][2*k+1] = sdata_n_w;
                if (k == 3 && i + 1 < n) pdata = tx_words[i+1];
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge serialclk);
        #2;
        checks++;
        if ({sdata_p_w, sdata_n_w, load} !== 3'b010) begin
            errors++;
            $display("FAIL reset_high_phase: p/n/load=%b need 010", {sdata_p_w, sdata_n_w, load});
        end
        @(negedge serialclk); #2;
        checks++;
        if ({sdata_p_w, sdata_n_w, load} !== 3'b010) begin
            errors++;
            $display("FAIL reset_low_phase: p/n/load=%b need 010", {sdata_p_w, sdata_n_w, load});
        end
        rst = 1'b0;
        pdata = 10'h3FF;
        for (int e = 1; e <= 6; e++) begin
            @(posedge serialclk); #2;
            checks++;
            if (load !== (e == 4)) begin
                errors++;
                $display("FAIL reset_load_edge%0d: load=%b need %b", e, load, (e == 4));
            end
            if (e == 5) begin
                checks++;
                if ({sdata_p_w, sdata_n_w} !== 2'b01) begin
                    errors++;
                    $display("FAIL reset_idle_edge5: p/n=%b need 01", {sdata_p_w, sdata_n_w});
                end
            end
            if (e == 6) begin
                checks++;
                if ({sdata_p_w, sdata_n_w} !== 2'b10) begin
                    errors++;
                    $display("FAIL reset_first_bit_edge6: p/n=%b need 10", {sdata_p_w, sdata_n_w});
                end
            end
        end
    endtask

    task automatic test_single_word;
        tx_words[0] = 10'b1101010010;
        xmit(1, 1'b0);
        checks++;
        if (rx_p[0] !== 10'h352) begin
            errors++;
            $display("FAIL single_p: got %b need %b", rx_p[0], 10'h352);
        end
        checks++;
        if (rx_n[0] !== 10'h0AD) begin
            errors++;
            $display("FAIL single_n: got %b need %b", rx_n[0], 10'h0AD);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp_w [3];
        exp_w[0] = 10'h3FF;
        exp_w[1] = 10'h000;
        exp_w[2] = 10'h155;
        for (int i = 0; i < 3; i++) tx_words[i] = exp_w[i];
        xmit(3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_p[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL b2b_p word%0d: got %b need %b", i, rx_p[i], exp_w[i]);
            end
            checks++;
            if (rx_n[i] !== ~exp_w[i]) begin
                errors++;
                $display("FAIL b2b_n word%0d: got %b need %b", i, rx_n[i], ~exp_w[i]);
            end
        end
        checks++;
        if (load_errs !== 0) begin
            errors++;
            $display("FAIL b2b_load_period: %0d misplaced load samples, need 0", load_errs);
        end
    endtask

    task automatic test_glitch;
        tx_words[0] = 10'h2AA;
        tx_words[1] = 10'h2AA;
        xmit(2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rx_p[i] !== 10'h2AA || rx_n[i] !== 10'h155) begin
                errors++;
                $display("FAIL glitch word%0d: p=%b n=%b need p=%b n=%b", i, rx_p[i], rx_n[i], 10'h2AA, 10'h155);
            end
        end
    endtask

    task automatic test_tristate;
        bit ok;
        wait_load(ok);
        if (!ok) return;
        pdata = 10'h155;
        @(posedge serialclk);                 // load edge E0
        @(posedge serialclk); #2;             // E0+1, bit0 = 1
        checks++;
        if ({sdata_p_w, sdata_n_w} !== 2'b10) begin
            errors++;
            $display("FAIL tri_before: p/n=%b need 10", {sdata_p_w, sdata_n_w});
        end
        @(negedge serialclk); #2;
        ti = 1'b1;
        checks++;
        if ({sdata_p_w, sdata_n_w} !== 2'b01) begin
            errors++;
            $display("FAIL tri_not_yet: p/n=%b need 01", {sdata_p_w, sdata_n_w});
        end
        for (int e = 2; e <= 3; e++) begin
            @(posedge serialclk); #2;
            checks++;
            if ({sdata_p_w, sdata_n_w} !== 2'b11) begin
                errors++;
                $display("FAIL tri_hz_high E0+%0d: p/n=%b need zz(11)", e, {sdata_p_w, sdata_n_w});
            end
            @(negedge serialclk); #2;
            checks++;
            if ({sdata_p_w, sdata_n_w} !== 2'b11) begin
                errors++;
                $display("FAIL tri_hz_low E0+%0d: p/n=%b need zz(11)", e, {sdata_p_w, sdata_n_w});
            end
        end
        ti = 1'b0;
        @(posedge serialclk); #2;             // E0+4, bit6 = 1, load high
        checks++;
        if ({sdata_p_w, sdata_n_w, load} !== 3'b101) begin
            errors++;
            $display("FAIL tri_resume_high: p/n/load=%b need 101", {sdata_p_w, sdata_n_w, load});
        end
        @(negedge serialclk); #2;             // bit7 = 0
        checks++;
        if ({sdata_p_w, sdata_n_w} !== 2'b01) begin
            errors++;
            $display("FAIL tri_resume_low: p/n=%b need 01", {sdata_p_w, sdata_n_w});
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        wait_load(ok);
        if (!ok) return;
        pdata = 10'h3FF;
        repeat (3) @(posedge serialclk);      // E0, E0+1, E0+2 -> cnt=2
        #2;
        checks++;
        if ({sdata_p_w, sdata_n_w} !== 2'b10) begin
            errors++;
            $display("FAIL areset_pre: p/n=%b need 10", {sdata_p_w, sdata_n_w});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sdata_p_w, sdata_n_w, load} !== 3'b010) begin
            errors++;
            $display("FAIL areset_immediate: p/n/load=%b need 010", {sdata_p_w, sdata_n_w, load});
        end
        @(posedge serialclk);
        @(negedge serialclk); #2;
        rst = 1'b0;
        pdata = 10'h155;
        for (int e = 1; e <= 5; e++) begin
            @(posedge serialclk); #2;
            checks++;
            if (load !== (e == 4)) begin
                errors++;
                $display("FAIL areset_load_edge%0d: load=%b need %b", e, load, (e == 4));
            end
        end
        tx_words[0] = 10'h0F3;
        xmit(1, 1'b0);
        checks++;
        if (rx_p[0] !== 10'h0F3 || rx_n[0] !== 10'h30C) begin
            errors++;
            $display("FAIL areset_recover: p=%b n=%b need p=%b n=%b", rx_p[0], rx_n[0], 10'h0F3, 10'h30C);
        end
    endtask

    initial begin
        rst   = 1'b1;
        ti    = 1'b0;
        pdata = 10'h000;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_glitch();
        test_tristate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
